// File: rtl/mnist_mlp_engine.sv
// Sequential two-layer binary-input MLP classifier: one MAC per clock, weights
// and biases streamed from an external synchronous ROM, argmax of the class scores.
module mnist_mlp_engine #(
    parameter int N_IN  = 784,
    parameter int N_HID = 16,
    parameter int N_OUT = 10,
    parameter int W_W   = 8,
    parameter int H_W   = 8,
    parameter int ACC_W = 24,
    parameter int SHIFT = 4,
    parameter int AW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         image_in,
    input  logic                    start,
    output logic [AW-1:0]           w_addr,
    input  logic signed [W_W-1:0]   w_data,
    output logic                    busy,
    output logic                    valid,
    output logic [3:0]              digit_out,
    output logic signed [ACC_W-1:0] score_out
);

    localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int CW   = $clog2(KMAX + 2);
    localparam int NMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int IW   = $clog2(NMAX);
    localparam int HIW  = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam logic signed [ACC_W-1:0] HMAX = ACC_W'((64'd1 << H_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           k;
    logic [IW-1:0]           idx;
    logic [N_IN-1:0]         img_reg, pix;
    logic signed [ACC_W-1:0] acc, best;
    logic [3:0]              best_idx;
    logic [H_W-1:0]          hid [N_HID];

    logic accept, running, drain, last_neuron, last_addr, addr_step, accum;
    logic valid_next, busy_next;
    logic [HIW-1:0]          hsel;
    logic signed [ACC_W-1:0] wx, hx, term, acc_fin, sh;
    logic [H_W-1:0]          h_new;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = L1;
            L1:      if (drain && last_neuron) state_next = L2;
            L2:      if (drain && last_neuron) state_next = DONE;
            DONE:    if (valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // k counts address cycles 0..K of a neuron; cycle K+1 is the drain, where the bias arrives.
    always_comb begin
        accept      = (state == IDLE) && start;
        running     = (state == L1) || (state == L2);
        drain       = ((state == L1) && (k == CW'(N_IN + 1))) ||
                      ((state == L2) && (k == CW'(N_HID + 1)));
        last_neuron = (state == L1) ? (idx == IW'(N_HID - 1)) : (idx == IW'(N_OUT - 1));
        last_addr   = (state == L2) && last_neuron && (k == CW'(N_HID));
        addr_step   = running && !drain && !last_addr;
        accum       = running && (k != '0) && !drain;
        valid_next  = (state == DONE) && !valid;
        busy_next   = running;
    end

    always_comb begin
        hsel    = HIW'(k - CW'(1));
        wx      = ACC_W'(w_data);
        hx      = ACC_W'($signed({1'b0, hid[hsel]}));
        term    = (state == L1) ? (pix[N_IN-1] ? wx : '0) : hx * wx;
        acc_fin = acc + wx;
        sh      = acc_fin >>> SHIFT;
        if (acc_fin[ACC_W-1])  h_new = '0;
        else if (sh > HMAX)    h_new = '1;
        else                   h_new = sh[H_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr    <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            digit_out <= '0;
            score_out <= '0;
            k         <= '0;
            idx       <= '0;
            acc       <= '0;
            best      <= '0;
            best_idx  <= '0;
            img_reg   <= '0;
            pix       <= '0;
        end else begin
            busy  <= busy_next;
            valid <= valid_next;
            if (valid_next) begin
                digit_out <= best_idx;
                score_out <= best;
            end
            if (accept) begin
                img_reg <= image_in;
                pix     <= image_in;
                w_addr  <= '0;
                k       <= '0;
                idx     <= '0;
                acc     <= '0;
            end else if (running) begin
                if (addr_step) w_addr <= w_addr + AW'(1);
                if (drain) begin
                    k   <= '0;
                    acc <= '0;
                    pix <= img_reg;
                    idx <= last_neuron ? '0 : idx + IW'(1);
                    // Class 0 always seeds the best; later classes replace only on strictly greater.
                    if ((state == L2) && ((idx == '0) || (acc_fin > best))) begin
                        best     <= acc_fin;
                        best_idx <= 4'(idx);
                    end
                end else begin
                    k <= k + CW'(1);
                    if (accum) begin
                        acc <= acc + term;
                        if (state == L1) pix <= pix << 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == L1) && drain) hid[HIW'(idx)] <= h_new;
    end

endmodule

// File: tb/tb_mnist_mlp_engine.sv
// Bench for mnist_mlp_engine on a 4-2-3 network: directed cases plus random
// ROM/image runs, checked against a plain-arithmetic model of the network.
module tb_mnist_mlp_engine;

    localparam int N_IN  = 4;
    localparam int N_HID = 2;
    localparam int N_OUT = 3;
    localparam int SHIFT = 0;
    localparam int ROM_N = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
    localparam int LAT   = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_IN-1:0]   image_in;
    logic              start;
    logic [15:0]       w_addr;
    logic signed [7:0] w_data = '0;
    logic              busy, valid;
    logic [3:0]        digit_out;
    logic signed [23:0] score_out;

    int rom [ROM_N];
    int vectors = 0;
    int miscompares = 0;

    mnist_mlp_engine #(
        .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W_W(8), .H_W(8),
        .ACC_W(24), .SHIFT(SHIFT), .AW(16)
    ) dut (
        .clk(clk), .rst(rst), .image_in(image_in), .start(start),
        .w_addr(w_addr), .w_data(w_data), .busy(busy), .valid(valid),
        .digit_out(digit_out), .score_out(score_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        w_data <= (w_addr < 16'(ROM_N)) ? 8'(rom[w_addr]) : 8'd0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input longint observed, input longint expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic load_default_rom;
        int init [ROM_N] = '{1, 2, 3, 4, 0,   -1, -1, -1, -1, 1,
                             1, 0, 0,   0, 1, 0,   1, 1, -5};
        rom = init;
    endtask

    function automatic longint wrap24(input longint v);
        longint r;
        r = v & 64'hFF_FFFF;
        if (r >= 64'h80_0000) r -= 64'h100_0000;
        return r;
    endfunction

    // Straight evaluation of the network from the ROM table.
    function automatic void ref_model(input logic [N_IN-1:0] img, output int dig, output longint sc);
        longint h [N_HID];
        longint a;
        for (int n = 0; n < N_HID; n++) begin
            a = rom[n * (N_IN + 1) + N_IN];
            for (int i = 0; i < N_IN; i++)
                if (img[N_IN - 1 - i]) a += rom[n * (N_IN + 1) + i];
            a = wrap24(a);
            if (a < 0) h[n] = 0;
            else begin
                a = a >>> SHIFT;
                h[n] = (a > 255) ? 255 : a;
            end
        end
        dig = 0;
        sc  = 0;
        for (int c = 0; c < N_OUT; c++) begin
            int base = N_HID * (N_IN + 1) + c * (N_HID + 1);
            a = rom[base + N_HID];
            for (int j = 0; j < N_HID; j++) a += h[j] * rom[base + j];
            a = wrap24(a);
            if (c == 0 || a > sc) begin
                sc  = a;
                dig = c;
            end
        end
    endfunction

    task automatic apply_stimulus(input string tag, input logic [N_IN-1:0] img,
                                  input int repulse_at, input logic [N_IN-1:0] img_late,
                                  input bit poke_done);
        int     exp_d, cyc, busy_cnt, stray;
        longint exp_s;
        bit     got;
        ref_model(img, exp_d, exp_s);
        image_in = img;
        start    = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && cyc < LAT + 10) begin
            cyc++;
            if (cyc == repulse_at) begin
                start    = 1'b1;
                image_in = img_late;
            end
            step();
            start = 1'b0;
            if (busy) busy_cnt++;
            if (valid) got = 1'b1;
        end
        check_output({tag, ".latency"}, cyc, LAT);
        check_output({tag, ".busy_cycles"}, busy_cnt, LAT - 1);
        check_output({tag, ".digit"}, digit_out, exp_d);
        check_output({tag, ".score"}, longint'(score_out), exp_s);
        if (poke_done) start = 1'b1;
        step();
        start = 1'b0;
        check_output({tag, ".valid_pulse"}, valid, 0);
        check_output({tag, ".digit_held"}, digit_out, exp_d);
        if (poke_done) begin
            stray = 0;
            repeat (4) begin
                step();
                if (busy || valid) stray++;
            end
            check_output({tag, ".start_in_done_ignored"}, stray, 0);
        end
    endtask

    initial begin
        int stray;
        rst      = 1'b1;
        start    = 1'b0;
        image_in = '0;
        load_default_rom();
        repeat (2) step();
        rst = 1'b0;
        check_output("reset.busy", busy, 0);
        check_output("reset.valid", valid, 0);
        check_output("reset.digit", digit_out, 0);
        check_output("reset.score", longint'(score_out), 0);
        check_output("reset.w_addr", w_addr, 0);

        apply_stimulus("basic", 4'b1010, -1, 4'b0000, 1'b1);
        apply_stimulus("empty", 4'b0000, -1, 4'b0000, 1'b0);

        image_in = 4'b1010;
        start    = 1'b1;
        step();
        start    = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midrst.busy", busy, 0);
        check_output("midrst.valid", valid, 0);
        check_output("midrst.digit", digit_out, 0);
        check_output("midrst.score", longint'(score_out), 0);
        check_output("midrst.w_addr", w_addr, 0);
        stray = 0;
        repeat (30) begin
            step();
            if (busy || valid) stray++;
        end
        check_output("midrst.quiet", stray, 0);
        apply_stimulus("after_rst", 4'b1010, -1, 4'b0000, 1'b0);
        apply_stimulus("back_to_back", 4'b0000, -1, 4'b0000, 1'b0);

        apply_stimulus("handshake", 4'b1010, 5, 4'b0101, 1'b0);

        rom[13] = 1;
        rom[14] = 0;
        apply_stimulus("tie", 4'b1010, -1, 4'b0000, 1'b0);

        load_default_rom();
        for (int i = 0; i < N_IN; i++) rom[i] = 100;
        apply_stimulus("saturate", 4'b1111, -1, 4'b0000, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < ROM_N; i++) rom[i] = int'($urandom_range(255)) - 128;
            apply_stimulus($sformatf("random%0d", r), N_IN'($urandom), -1, 4'b0000, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
